// File: rtl/pll_phase_ctrl.sv
// Lock-qualified reset release and dynamic phase-shift sequencer for the ECP5 EHXPLLL.
// Drives PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG from a valid/ready request port.
module pll_phase_ctrl #(
    parameter int LOCK_CYCLES = 1024,
    parameter int SETUP_W     = 2,
    parameter int PULSE_W     = 4,
    parameter int GAP_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk25,
    input  logic             resetn,
    input  logic             pll_locked,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             phaseloadreg,
    output logic             sys_rst_n
);

    localparam int LCW  = $clog2(LOCK_CYCLES + 1);
    localparam int TMAX = (SETUP_W > PULSE_W) ? ((SETUP_W > GAP_W) ? SETUP_W : GAP_W)
                                              : ((PULSE_W > GAP_W) ? PULSE_W : GAP_W);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        WAIT_LOCK, IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI, DONE
    } state_t;

    state_t           state, state_n;
    logic             lock_s1, lock_s2;
    logic [LCW-1:0]   lock_cnt, lock_cnt_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             req_ready_n, busy_n, done_n, err_n;
    logic [1:0]       phasesel_n;
    logic             phasedir_n, phasestep_n, phaseloadreg_n, sys_rst_n_n;

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            state        <= WAIT_LOCK;
            lock_s1      <= 1'b0;
            lock_s2      <= 1'b0;
            lock_cnt     <= '0;
            tcnt         <= '0;
            rem          <= '0;
            req_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            phasesel     <= 2'b00;
            phasedir     <= 1'b0;
            phasestep    <= 1'b1;
            phaseloadreg <= 1'b1;
            sys_rst_n    <= 1'b0;
        end else begin
            state        <= state_n;
            lock_s1      <= pll_locked;
            lock_s2      <= lock_s1;
            lock_cnt     <= lock_cnt_n;
            tcnt         <= tcnt_n;
            rem          <= rem_n;
            req_ready    <= req_ready_n;
            busy         <= busy_n;
            done         <= done_n;
            err          <= err_n;
            phasesel     <= phasesel_n;
            phasedir     <= phasedir_n;
            phasestep    <= phasestep_n;
            phaseloadreg <= phaseloadreg_n;
            sys_rst_n    <= sys_rst_n_n;
        end
    end

    always_comb begin
        state_n        = state;
        lock_cnt_n     = lock_cnt;
        tcnt_n         = tcnt;
        rem_n          = rem;
        req_ready_n    = req_ready;
        busy_n         = busy;
        done_n         = 1'b0;
        err_n          = 1'b0;
        phasesel_n     = phasesel;
        phasedir_n     = phasedir;
        phasestep_n    = phasestep;
        phaseloadreg_n = phaseloadreg;
        sys_rst_n_n    = sys_rst_n;

        unique case (state)
            WAIT_LOCK: begin
                if (lock_s2) begin
                    lock_cnt_n = lock_cnt + 1'b1;
                    if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                        state_n     = IDLE;
                        sys_rst_n_n = 1'b1;
                        req_ready_n = 1'b1;
                    end
                end else begin
                    lock_cnt_n = '0;
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    phasesel_n  = req_sel;
                    phasedir_n  = req_dir;
                    rem_n       = req_steps;
                    busy_n      = 1'b1;
                    req_ready_n = 1'b0;
                    tcnt_n      = '0;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                if (tcnt == TW'(SETUP_W - 1)) begin
                    tcnt_n = '0;
                    if (rem != '0) begin
                        state_n     = STEP_LO;
                        phasestep_n = 1'b0;
                    end else begin
                        state_n        = LOAD_LO;
                        phaseloadreg_n = 1'b0;
                    end
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            STEP_LO: begin
                if (tcnt == TW'(PULSE_W - 1)) begin
                    tcnt_n      = '0;
                    phasestep_n = 1'b1;
                    state_n     = STEP_HI;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            // The step counter is decremented as each gap ends, so the exit test uses the pre-decrement value
            STEP_HI: begin
                if (tcnt == TW'(GAP_W - 1)) begin
                    tcnt_n = '0;
                    rem_n  = rem - 1'b1;
                    if (rem != CNT_W'(1)) begin
                        state_n     = STEP_LO;
                        phasestep_n = 1'b0;
                    end else begin
                        state_n        = LOAD_LO;
                        phaseloadreg_n = 1'b0;
                    end
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            LOAD_LO: begin
                if (tcnt == TW'(PULSE_W - 1)) begin
                    tcnt_n         = '0;
                    phaseloadreg_n = 1'b1;
                    state_n        = LOAD_HI;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            LOAD_HI: begin
                if (tcnt == TW'(GAP_W - 1)) begin
                    tcnt_n  = '0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            DONE: begin
                busy_n      = 1'b0;
                req_ready_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = WAIT_LOCK;
        endcase

        // Lock loss overrides everything, including a handshake in the same cycle
        if (state != WAIT_LOCK && !lock_s2) begin
            state_n        = WAIT_LOCK;
            lock_cnt_n     = '0;
            tcnt_n         = '0;
            sys_rst_n_n    = 1'b0;
            phasestep_n    = 1'b1;
            phaseloadreg_n = 1'b1;
            busy_n         = 1'b0;
            req_ready_n    = 1'b0;
            done_n         = 1'b0;
            err_n          = (state != IDLE);
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: lock qualification, request vector table, and
// hand-written sequences for back-to-back requests, lock loss and mid-operation reset.
module tb_pll_phase_ctrl;

    logic       clk25 = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       busy, done, err;
    logic [1:0] phasesel;
    logic       phasedir, phasestep, phaseloadreg, sys_rst_n;

    int checks = 0;
    int errors = 0;

    always #20 clk25 = ~clk25;

    pll_phase_ctrl #(.LOCK_CYCLES(16)) dut (
        .clk25(clk25), .resetn(resetn), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps), .busy(busy), .done(done),
        .err(err), .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg), .sys_rst_n(sys_rst_n)
    );

    // Observed vector: {sys_rst_n, req_ready, busy, done, err, phasesel, phasedir, phasestep, phaseloadreg}
    wire [9:0] obs = {sys_rst_n, req_ready, busy, done, err, phasesel, phasedir, phasestep, phaseloadreg};
    localparam logic [9:0] RST_VEC = 10'b0_0_0_0_0_00_0_1_1;

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        logic [7:0] steps;
        int         expK;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected outputs t edges after acceptance, defaults SETUP_W=2, PULSE_W=4, GAP_W=4
    function automatic logic [9:0] expectOp(int t, logic [1:0] sel, logic dir, int n, int k);
        logic ps, pl;
        ps = !(t >= 2 && ((t - 2) / 8) < n && ((t - 2) % 8) < 4);
        pl = !(t >= 2 + 8 * n && t < 6 + 8 * n);
        return {1'b1, (t > k), (t <= k), (t == k), 1'b0, sel, dir, ps, pl};
    endfunction

    task automatic waitReady(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (req_ready) break;
            @(negedge clk25);
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("[TB] FAIL %s: req_ready got 0 expected 1 within %0d cycles", name, bound);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        waitReady($sformatf("ready before sel=%0d steps=%0d", v.sel, v.steps), 100);
        req_valid = 1'b1;
        req_sel   = v.sel;
        req_dir   = v.dir;
        req_steps = v.steps;
        for (int t = 0; t <= v.expK + 1; t++) begin
            @(negedge clk25);
            if (t == 0) req_valid = 1'b0;
            checkOutput($sformatf("op sel=%0d steps=%0d t=%0d", v.sel, v.steps, t), obs,
                        expectOp(t, v.sel, v.dir, int'(v.steps), v.expK));
        end
    endtask

    initial begin
        resetn     = 1'b0;
        pll_locked = 1'b0;
        req_valid  = 1'b0;
        req_sel    = 2'b00;
        req_dir    = 1'b0;
        req_steps  = 8'd0;

        vecs[0] = '{2'b01, 1'b1, 8'd3,   34};
        vecs[1] = '{2'b00, 1'b0, 8'd0,   10};
        vecs[2] = '{2'b10, 1'b1, 8'd1,   18};
        vecs[3] = '{2'b11, 1'b0, 8'd2,   26};
        vecs[4] = '{2'b10, 1'b0, 8'd255, 2050};

        // Reset values, with lock asserted so reset alone holds them
        repeat (3) @(negedge clk25);
        pll_locked = 1'b1;
        repeat (3) @(negedge clk25);
        checkOutput("reset values", obs, RST_VEC);

        // Lock qualification: sys_rst_n and req_ready rise at edge 18 after lock
        pll_locked = 1'b0;
        repeat (3) @(negedge clk25);
        resetn = 1'b1;
        @(negedge clk25);
        pll_locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk25);
            checkOutput($sformatf("lock release e=%0d", e), {8'b0, sys_rst_n, req_ready},
                        {8'b0, (e >= 18), (e >= 18)});
        end

        // Lock glitch: one low cycle restarts the count, release 18 edges after second rise
        resetn     = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk25);
        resetn     = 1'b1;
        pll_locked = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk25);
            checkOutput($sformatf("lock glitch e=%0d", e), {9'b0, sys_rst_n}, {9'b0, (e >= 29)});
            if (e == 10) pll_locked = 1'b0;
            if (e == 11) pll_locked = 1'b1;
        end

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Second request held valid while busy is taken only once req_ready returns
        waitReady("ready before back-to-back", 100);
        req_valid = 1'b1;
        req_sel   = 2'b01;
        req_dir   = 1'b1;
        req_steps = 8'd3;
        for (int t = 0; t <= 35; t++) begin
            @(negedge clk25);
            if (t == 0) begin
                req_sel   = 2'b11;
                req_dir   = 1'b0;
                req_steps = 8'd0;
            end
            checkOutput($sformatf("b2b first t=%0d", t), obs, expectOp(t, 2'b01, 1'b1, 3, 34));
        end
        for (int t = 0; t <= 11; t++) begin
            @(negedge clk25);
            if (t == 0) req_valid = 1'b0;
            checkOutput($sformatf("b2b second t=%0d", t), obs, expectOp(t, 2'b11, 1'b0, 0, 10));
        end

        // Lock loss during the second STEP_LO takes effect 3 edges after pll_locked falls
        waitReady("ready before lock loss", 100);
        req_valid = 1'b1;
        req_sel   = 2'b10;
        req_dir   = 1'b0;
        req_steps = 8'd3;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk25);
            if (t == 0) req_valid = 1'b0;
            if (t <= 13)
                checkOutput($sformatf("lock loss t=%0d", t), obs, expectOp(t, 2'b10, 1'b0, 3, 34));
            else if (t == 14)
                checkOutput("lock loss err pulse", obs, 10'b0_0_0_0_1_10_0_1_1);
            else
                checkOutput($sformatf("lock loss after t=%0d", t), obs, 10'b0_0_0_0_0_10_0_1_1);
            if (t == 11) pll_locked = 1'b0;
        end
        pll_locked = 1'b1;
        waitReady("relock after loss", 100);
        checkOutput("relock sys_rst_n", {9'b0, sys_rst_n}, 10'd1);

        // Mid-operation reset returns every output to reset values with no err pulse
        req_valid = 1'b1;
        req_sel   = 2'b01;
        req_dir   = 1'b1;
        req_steps = 8'd2;
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk25);
            if (t == 0) req_valid = 1'b0;
            checkOutput($sformatf("mid reset t=%0d", t), obs, expectOp(t, 2'b01, 1'b1, 2, 26));
        end
        resetn = 1'b0;
        @(negedge clk25);
        checkOutput("mid reset values", obs, RST_VEC);
        @(negedge clk25);
        checkOutput("mid reset hold", obs, RST_VEC);
        resetn = 1'b1;
        waitReady("ready after mid reset", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
